// File: rtl/abm_ring_sequencer.sv
// Walks the ABM->PCIe block mover across a host ring of equally sized slots,
// one transfer per frame, gated by host-returned buffer credits.
module abm_ring_sequencer #(
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] ring_base,
  input  logic [31:0]   ring_stride,
  input  logic [IW-1:0] ring_count,
  input  logic          frame_ready,
  input  logic          buf_release,
  output logic          mover_start,
  output logic [AW-1:0] mover_dst_addr,
  input  logic          mover_idle,
  output logic          busy,
  output logic [IW-1:0] slot_index,
  output logic [IW-1:0] free_bufs,
  output logic [CW-1:0] frames_sent,
  output logic [CW-1:0] frames_dropped
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ARM        = 3'd1;
  localparam logic [2:0] S_WAIT_FRAME = 3'd2;
  localparam logic [2:0] S_LAUNCH     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY  = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE  = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic          enable_d_reg;
  logic          pending_reg;
  logic [AW-1:0] base_reg;
  logic [31:0]   stride_reg;
  logic [IW-1:0] count_reg;
  logic [AW-1:0] offset_reg;
  logic [AW-1:0] addr_reg;
  logic [IW-1:0] slot_reg;
  logic [IW-1:0] free_reg;
  logic [CW-1:0] sent_reg;
  logic [CW-1:0] dropped_reg;

  logic launching, completing, ring_live, slot_wrap, enable_rise;

  assign launching   = (state_reg == S_LAUNCH);
  assign completing  = (state_reg == S_WAIT_IDLE) && mover_idle;
  assign ring_live   = (state_reg != S_IDLE) && (state_reg != S_ARM);
  assign slot_wrap   = (slot_reg == count_reg - IW'(1));
  assign enable_rise = enable && !enable_d_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:
        if (enable_rise && (ring_base != '0) && (ring_count != '0)) state_next = S_ARM;
      S_ARM:
        state_next = S_WAIT_FRAME;
      // Run control wins over a waiting frame: a disabled ring never starts new work.
      S_WAIT_FRAME:
        if (!enable)                                state_next = S_IDLE;
        else if (pending_reg && (free_reg != '0))   state_next = S_LAUNCH;
      S_LAUNCH:
        state_next = S_WAIT_BUSY;
      S_WAIT_BUSY:
        if (!mover_idle) state_next = S_WAIT_IDLE;
      S_WAIT_IDLE:
        if (mover_idle) state_next = enable ? S_WAIT_FRAME : S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      enable_d_reg <= 1'b0;
      pending_reg  <= 1'b0;
      base_reg     <= '0;
      stride_reg   <= '0;
      count_reg    <= '0;
      offset_reg   <= '0;
      addr_reg     <= '0;
      slot_reg     <= '0;
      free_reg     <= '0;
      sent_reg     <= '0;
      dropped_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      enable_d_reg <= enable;

      // A frame arriving on the launch cycle refills the slot being vacated.
      if (!ring_live || (state_next == S_IDLE)) pending_reg <= 1'b0;
      else if (frame_ready)                    pending_reg <= 1'b1;
      else if (launching)                      pending_reg <= 1'b0;

      if (ring_live && frame_ready && pending_reg && !launching)
        dropped_reg <= dropped_reg + CW'(1);

      if (state_reg == S_ARM) begin
        base_reg   <= ring_base;
        stride_reg <= ring_stride;
        count_reg  <= ring_count;
        free_reg   <= ring_count;
        slot_reg   <= '0;
        offset_reg <= '0;
      end else begin
        if (launching && !buf_release)
          free_reg <= free_reg - IW'(1);
        else if (!launching && buf_release && (free_reg < count_reg))
          free_reg <= free_reg + IW'(1);

        if (completing) begin
          sent_reg <= sent_reg + CW'(1);
          if (slot_wrap) begin
            slot_reg   <= '0;
            offset_reg <= '0;
          end else begin
            slot_reg   <= slot_reg + IW'(1);
            offset_reg <= offset_reg + AW'(stride_reg);
          end
        end
      end

      if (state_next == S_LAUNCH) addr_reg <= base_reg + offset_reg;
    end
  end

  assign mover_start    = launching;
  assign mover_dst_addr = addr_reg;
  assign busy           = (state_reg != S_IDLE);
  assign slot_index     = slot_reg;
  assign free_bufs      = free_reg;
  assign frames_sent    = sent_reg;
  assign frames_dropped = dropped_reg;

endmodule

// File: tb/tb_abm_ring_sequencer.sv
// Directed ring scenarios followed by randomized traffic, all checked each
// cycle against a transaction-level model of the ring sequencer.
module tb_abm_ring_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, frame_ready, buf_release, mover_idle;
  logic [63:0] ring_base;
  logic [31:0] ring_stride;
  logic [15:0] ring_count;
  logic        mover_start, busy;
  logic [63:0] mover_dst_addr;
  logic [15:0] slot_index, free_bufs;
  logic [31:0] frames_sent, frames_dropped;

  abm_ring_sequencer #(.AW(64), .CW(32), .IW(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ring_base(ring_base), .ring_stride(ring_stride), .ring_count(ring_count),
    .frame_ready(frame_ready), .buf_release(buf_release),
    .mover_start(mover_start), .mover_dst_addr(mover_dst_addr), .mover_idle(mover_idle),
    .busy(busy), .slot_index(slot_index), .free_bufs(free_bufs),
    .frames_sent(frames_sent), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit ck_on = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ring position as slot number, address = base + slot*stride.
  bit          m_active, m_arming, m_waiting, m_launch, m_inflight, m_seen_busy;
  bit          m_pending, m_en_prev;
  logic [63:0] m_base, m_addr;
  logic [31:0] m_stride, m_sent, m_dropped;
  int          m_cnt, m_slot, m_free;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_arming = 0; m_waiting = 0; m_launch = 0; m_inflight = 0;
      m_seen_busy = 0; m_pending = 0; m_en_prev = 0;
      m_base = 0; m_addr = 0; m_stride = 0; m_sent = 0; m_dropped = 0;
      m_cnt = 0; m_slot = 0; m_free = 0;
    end else begin
      bit rise, live, nxt_pending;
      int nfree;
      rise = enable && !m_en_prev;
      m_en_prev = enable;
      live = m_active && !m_arming;
      nxt_pending = m_pending;
      if (live && frame_ready) begin
        if (m_pending && !m_launch) m_dropped = m_dropped + 1;
        nxt_pending = 1;
      end else if (m_launch) nxt_pending = 0;
      if (!live) nxt_pending = 0;
      nfree = m_free - (m_launch ? 1 : 0) + (buf_release ? 1 : 0);
      if (nfree > m_cnt) nfree = m_cnt;

      if (!m_active) begin
        if (rise && ring_base != 0 && ring_count != 0) begin
          m_active = 1; m_arming = 1;
        end
      end else if (m_arming) begin
        m_base = ring_base; m_stride = ring_stride; m_cnt = int'(ring_count);
        nfree = m_cnt; m_slot = 0; m_arming = 0; m_waiting = 1;
      end else if (m_waiting) begin
        if (!enable) begin
          m_active = 0; m_waiting = 0;
        end else if (m_pending && m_free != 0) begin
          m_waiting = 0; m_launch = 1;
          m_addr = m_base + 64'(m_slot) * 64'(m_stride);
        end
      end else if (m_launch) begin
        m_launch = 0; m_inflight = 1; m_seen_busy = 0;
      end else if (!m_seen_busy) begin
        if (!mover_idle) m_seen_busy = 1;
      end else if (mover_idle) begin
        m_sent = m_sent + 1;
        m_slot = (m_slot + 1) % m_cnt;
        m_inflight = 0; m_seen_busy = 0;
        if (enable) m_waiting = 1; else m_active = 0;
      end
      m_free = nfree;
      m_pending = m_active ? nxt_pending : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ck_on) begin
      check("start", 64'(mover_start), 64'(m_launch));
      check("busy", 64'(busy), 64'(m_active));
      check("dst_addr", mover_dst_addr, m_addr);
      check("slot_index", 64'(slot_index), 64'(m_slot));
      check("free_bufs", 64'(free_bufs), 64'(m_free));
      check("frames_sent", 64'(frames_sent), 64'(m_sent));
      check("frames_dropped", 64'(frames_dropped), 64'(m_dropped));
    end
  end

  // Mover: drops idle 1-3 cycles after a start, stays busy 1-5 cycles.
  initial begin
    mover_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (mover_start === 1'b1) begin
        int d, l;
        $display("launch addr=%h slot=%0d t=%0t", mover_dst_addr, slot_index, $time);
        d = $urandom_range(0, 2);
        l = $urandom_range(1, 5);
        repeat (d) @(posedge clk);
        @(posedge clk); #1 mover_idle = 1'b0;
        repeat (l) @(posedge clk);
        #1 mover_idle = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_ready = 1'b1; tick(1); frame_ready = 1'b0;
  endtask

  task automatic pulse_release();
    buf_release = 1'b1; tick(1); buf_release = 1'b0;
  endtask

  task automatic wait_start(output logic [63:0] a);
    int k = 0;
    do begin @(negedge clk); k++; end while (mover_start !== 1'b1 && k < 300);
    check("start_timeout", 64'(mover_start), 64'd1);
    a = mover_dst_addr;
    tick(1);
  endtask

  task automatic wait_settled();
    int k = 0;
    do begin @(negedge clk); k++; end while (!(m_waiting || !m_active) && k < 300);
    check("settle_timeout", 64'(m_waiting || !m_active), 64'd1);
    tick(1);
  endtask

  logic [63:0] a0, a1, a2, a3;

  initial begin
    reset = 1; enable = 0; frame_ready = 0; buf_release = 0;
    ring_base = 64'h1_0000_0000; ring_stride = 32'h0010_0000; ring_count = 16'd3;
    tick(1);
    ck_on = 1;
    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_free", 64'(free_bufs), 64'd0);
    reset = 0; enable = 1;
    tick(3);
    check("arm_free", 64'(free_bufs), 64'd3);

    // Three frames fill the ring; the fourth waits for a credit.
    pulse_frame(); wait_start(a0); wait_settled();
    pulse_frame(); wait_start(a1); wait_settled();
    pulse_frame(); wait_start(a2); wait_settled();
    pulse_frame(); tick(10);
    check("t1_addr0", a0, 64'h1_0000_0000);
    check("t1_addr1", a1, 64'h1_0010_0000);
    check("t1_addr2", a2, 64'h1_0020_0000);
    check("t1_free", 64'(free_bufs), 64'd0);
    check("t1_sent", 64'(frames_sent), 64'd3);

    pulse_release(); wait_start(a3); wait_settled();
    check("t2_wrap_addr", a3, 64'h1_0000_0000);
    check("t2_sent", 64'(frames_sent), 64'd4);
    check("t2_slot", 64'(slot_index), 64'd1);

    pulse_frame(); tick(1); pulse_frame(); tick(1); pulse_frame(); tick(2);
    check("t3_dropped", 64'(frames_dropped), 64'd2);
    check("t3_busy", 64'(busy), 64'd1);

    // Disable during WAIT_IDLE: transfer finishes, then the block idles.
    pulse_release(); wait_start(a0);
    check("t4_addr", a0, 64'h1_0010_0000);
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!m_seen_busy && k < 100);
      check("t4_busy_timeout", 64'(m_seen_busy), 64'd1);
    end
    tick(1);
    enable = 0;
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (busy === 1'b1 && k < 100);
    end
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_sent", 64'(frames_sent), 64'd5);
    check("t4_addr_hold", mover_dst_addr, 64'h1_0010_0000);
    tick(2);
    enable = 1; tick(3);
    check("t4_slot", 64'(slot_index), 64'd0);
    check("t4_free", 64'(free_bufs), 64'd3);

    // Frame on the launch cycle is accepted without a drop.
    pulse_frame(); tick(1);
    pulse_frame();
    wait_settled(); wait_start(a1); wait_settled();
    check("t5_dropped", 64'(frames_dropped), 64'd2);
    check("t5_sent", 64'(frames_sent), 64'd7);
    check("t5_addr", a1, 64'h1_0010_0000);
    pulse_release(); pulse_release(); pulse_release(); tick(1);
    check("t5_free_sat", 64'(free_bufs), 64'd3);

    // Reset during WAIT_BUSY.
    pulse_frame(); wait_start(a2);
    reset = 1; enable = 0; tick(1);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_addr", mover_dst_addr, 64'd0);
    check("t6_sent", 64'(frames_sent), 64'd0);
    check("t6_dropped", 64'(frames_dropped), 64'd0);
    reset = 0; tick(10);
    ring_base = 64'd0; enable = 1; tick(5);
    check("t6_no_arm", 64'(busy), 64'd0);

    // Randomized traffic.
    enable = 0; reset = 1; tick(2); reset = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        ring_base   = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom(), $urandom()};
        ring_stride = $urandom_range(0, 1) ? 32'h0010_0000 : $urandom();
        ring_count  = 16'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      reset       = ($urandom_range(0, 999) == 0);
      frame_ready = ($urandom_range(0, 3) == 0);
      buf_release = ($urandom_range(0, 4) == 0);
      tick(1);
    end
    reset = 0; frame_ready = 0; buf_release = 0;
    tick(2);
    ck_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
